// File: rtl/arb_pkg.sv
// arb_pkg: shared helpers for the round-robin arbitrating mux.
package arb_pkg;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/arb_mux_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or after ptr wins.
module rr_pick import arb_pkg::*; #(
   parameter int N = 2,
   localparam int IDXW = idx_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] grant_idx,
   output logic            any
);
   logic [IDXW-1:0] j;
   always_comb begin
      grant = '0;
      grant_idx = '0;
      any = 1'b0;
      j = '0;
      // Walk from the farthest slot back to ptr so the nearest requester lands last.
      for (int k = N - 1; k >= 0; k--) begin
         j = IDXW'((int'(ptr) + k) % N);
         if (req[j]) begin
            grant = '0;
            grant[j] = 1'b1;
            grant_idx = j;
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-channel round-robin arbitrating mux with a registered valid/ready output.
module arb_mux_rr import arb_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int N = 2,
   localparam int IDXW = idx_w(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [IDXW-1:0]      out_idx,
   input  logic                 out_ready
);
   logic [IDXW-1:0]  ptr_q, ptr_d, idx_q, idx_d, grant_idx;
   logic [WIDTH-1:0] data_q, data_d;
   logic [N-1:0]     grant;
   logic             valid_q, valid_d, any, can_load, xfer;
   rr_pick #(.N(N)) u_pick (
      .req       (in_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );
   always_comb begin
      can_load = !valid_q || out_ready;
      xfer = can_load && any;
      in_ready = can_load ? grant : '0;
      valid_d = xfer || (valid_q && !out_ready);
      data_d = xfer ? in_data[int'(grant_idx)*WIDTH +: WIDTH] : data_q;
      idx_d = xfer ? grant_idx : idx_q;
      ptr_d = !xfer ? ptr_q : (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + IDXW'(1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q <= '0;
         idx_q <= '0;
         ptr_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q <= data_d;
         idx_q <= idx_d;
         ptr_q <= ptr_d;
      end
   end
   assign out_valid = valid_q;
   assign out_data = data_q;
   assign out_idx = idx_q;
endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: random + directed checks of arb_mux_rr against a behavioural model (N=4) and a queue scoreboard (N=1).
module tb_arb_mux_rr;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]   v4, r4;
   logic [127:0] d4;
   logic         ov4, ordy;
   logic [31:0]  od4;
   logic [1:0]   oi4;
   logic         v1, r1, ov1, ordy1;
   logic [7:0]   d1, od1;
   logic [0:0]   oi1;

   arb_mux_rr #(.WIDTH(32), .N(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4),
      .out_valid(ov4), .out_data(od4), .out_idx(oi4), .out_ready(ordy)
   );
   arb_mux_rr #(.WIDTH(8), .N(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(r1),
      .out_valid(ov1), .out_data(od1), .out_idx(oi1), .out_ready(ordy1)
   );

   int errs = 0;
   int checks = 0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
      end
   endtask

   // Behavioural model of the N=4 instance.
   int          mp, mi;
   bit          mv, started;
   logic [31:0] md;
   function automatic int pick();
      for (int k = 0; k < 4; k++) if (v4[(mp + k) % 4]) return (mp + k) % 4;
      return -1;
   endfunction
   function automatic logic [3:0] exp_ready();
      int g = pick();
      if ((!mv || ordy) && g >= 0) return 4'(1 << g);
      return 4'b0;
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         mp <= 0;
         mv <= 1'b0;
         md <= '0;
         mi <= 0;
         started <= 1'b1;
      end else if (exp_ready() != 4'b0) begin
         mi <= pick();
         md <= d4[pick()*32 +: 32];
         mv <= 1'b1;
         mp <= (pick() + 1) % 4;
      end else if (mv && ordy) mv <= 1'b0;
   end
   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("rdy", r4, exp_ready());
         chk("ov", ov4, mv);
         chk("data", od4, md);
         chk("idx", oi4, mi);
      end
   end

   // N=1 scoreboard: the queue mirrors the single output register.
   logic [7:0] q1[$];
   bit         acc1 = 1'b0;
   bit         er1;
   int         n1out = 0;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         q1.delete();
         acc1 = 1'b0;
      end else begin
         er1 = (q1.size() == 0) || ordy1;
         chk("n1_rdy", r1, er1);
         chk("n1_ov", ov1, q1.size() != 0);
         if (q1.size() != 0) begin
            chk("n1_data", od1, q1[0]);
            chk("n1_idx", oi1, 0);
            if (ordy1) begin
               void'(q1.pop_front());
               n1out++;
            end
         end
         acc1 = v1 && er1;
         if (acc1) q1.push_back(d1);
      end
   end
   initial begin
      v1 = 1'b1;
      d1 = 8'h00;
      ordy1 = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (acc1) d1 = d1 + 8'd1;
         ordy1 = 1'($urandom % 2);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] acc;
   initial begin
      v4 = 4'hF;
      ordy = 1'b1;
      for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      cyc();
      cyc();
      chk("rst_ov", ov4, 0);
      chk("rst_data", od4, 0);
      chk("rst_idx", oi4, 0);
      chk("rst_rdy", r4, 4'b0001);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("rr_idx", oi4, k % 4);
         chk("rr_data", od4, 32'hA000_0000 + 32'(k % 4));
      end
      v4 = 4'b0100;
      d4[64 +: 32] = 32'hDEAD_BEEF;
      cyc();
      chk("bp_load", od4, 32'hDEAD_BEEF);
      ordy = 1'b0;
      v4 = 4'b1011;
      #1;
      chk("bp_rdy0", r4, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("bp_data", od4, 32'hDEAD_BEEF);
         chk("bp_idx", oi4, 2);
         chk("bp_ov", ov4, 1);
         chk("bp_rdy", r4, 4'b0000);
      end
      ordy = 1'b1;
      #1;
      chk("bp_release_rdy", r4, 4'b1000);
      cyc();
      chk("bp_next_idx", oi4, 3);
      chk("bp_next_ov", ov4, 1);
      v4 = 4'b0010;
      cyc();
      chk("sp_first", oi4, 1);
      v4 = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("sp_alt", oi4, (k % 2 == 0) ? 3 : 1);
      end
      v4 = 4'hF;
      cyc();
      chk("sp_ptr2", oi4, 2);
      ordy = 1'b0;
      v4 = 4'b0;
      cyc();
      chk("mr_held", ov4, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mr_ov", ov4, 0);
      chk("mr_data", od4, 0);
      v4 = 4'hF;
      #1;
      chk("mr_ptr0", r4, 4'b0001);
      acc = 4'hF;
      repeat (2000) begin
         for (int i = 0; i < 4; i++) begin
            if (!v4[i] || acc[i]) begin
               v4[i] = 1'($urandom % 2);
               d4[i*32 +: 32] = $urandom;
            end
         end
         ordy = ($urandom % 4) != 0;
         acc = exp_ready();
         cyc();
      end
      chk("n1_count", 32'(n1out > 500), 1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/arb_mux_rr.md
# arb_mux_rr

Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output stage. It supersedes the fixed 2:1 32-bit select mux wherever several producers share one consumer, for example I-cache and D-cache refill requests contending for the single memory port. It chooses one channel per cycle by round-robin and returns the winning channel index with the data. Every input and output uses a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32, data width per channel (≥1)
- N, 2, number of input channels (≥1)
- IDXW, max(1, clog2(N)), index width (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  N  per-channel request valid
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel accept; combinational
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  registered data
- out_idx  out  IDXW  source channel of out_data
- out_ready  in  1  consumer accepts the output word

## Operation
- Internal state:
  - round-robin pointer ptr (IDXW bits, range 0..N-1)
  - output register {out_valid, out_data, out_idx}
- can_load = !out_valid | out_ready.
- Grant: the first channel i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N). At most one grant per cycle.
- in_ready[i] = can_load & grant[i]. in_ready is 0 for all non-granted channels and for every channel when !can_load.
  - in_ready may depend on in_valid and out_ready.
  - in_ready must not depend on in_data.
- Transfer on channel i happens when in_valid[i] & in_ready[i] on a rising edge. On transfer:
  - out_data ← channel i data; out_idx ← i; out_valid ← 1
  - ptr ← i+1, or 0 when i = N-1
- No transfer and out_valid & out_ready: out_valid ← 0. Data and idx keep their old value.
- No transfer and no drain: all state holds.
- ptr changes only on a transfer. An idle channel never blocks others.
- N=1: degenerates to a one-entry pipeline register; ptr is constant 0.
- Producers must hold in_valid and in_data stable until accepted. The block does not check this.

## Timing
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, out_idx=0, ptr=0
  - in_ready therefore reflects only the grant, with can_load=1
- Reset mid-operation discards any held word without a handshake.
- Latency: accepted word visible on out_data exactly 1 cycle after the transfer edge.
- Throughput: 1 word/cycle while out_ready=1. A simultaneous drain and load in the same cycle is required, with no bubble.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_idx are stable
  - all in_ready are 0
- Fairness: with all N channels continuously valid and out_ready=1, grants follow ptr, ptr+1, … cyclically. No channel waits more than N-1 transfers.
- Wrap: grant to channel N-1 sets ptr=0.

## Structure
- Shared package arb_pkg holds the IDXW derivation helper (clog2 with minimum 1). Also reuse the existing MUX_SEL-style constants if present.
- One sub-module: rr_pick, purely combinational.
  - Inputs: req[N], ptr.
  - Outputs: grant one-hot[N], grant_idx[IDXW], any.
  - Implementation: a double-width rotate or a masked two-pass priority encoder.
- Top level holds ptr, the output register and the handshake logic.

## Test plan
- Reset: assert rst with all in_valid=1.
  - During reset: the output register and ptr load their reset values; out_valid=0.
  - First cycle after release: channel 0 is granted; in_ready=…01.
- Round-robin, N=4, WIDTH=32, all valid, out_ready=1:
  - Channel i drives 0xA000_000i.
  - out_idx sequence is 0,1,2,3,0; each out_data matches its index.
  - Wrap from ptr=3 to 0 is observed.
- Backpressure: load 0xDEAD_BEEF from channel 2, then hold out_ready=0 for 3 cycles.
  - out_data, out_idx=2 and out_valid=1 stay stable.
  - All in_ready=0.
  - Releasing out_ready drains, and the next transfer happens in the same cycle.
- Sparse requests: only channels 1 and 3 valid, starting from ptr=2.
  - Grants alternate 3,1,3,…; ptr ends at 0 or 2 accordingly.
- Reset mid-operation: out_valid=1, out_ready=0, assert rst for 1 cycle.
  - Next cycle out_valid=0 and ptr=0.
  - The held word is never handshaken.
- N=1, WIDTH=8, continuous valid, random out_ready:
  - Output word stream equals input stream exactly, with no loss or duplication.
  - out_idx is always 0.
